// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and constants for the Booth product accumulator
//                (controller state encoding, default widths, saturation limits).
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

  // Default widths: product from the 8x8 multiplier, accumulator, run length.
  localparam int DEF_PROD_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_CNT_W  = 4;

  // Saturation limits of the default-width accumulator.
  localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/booth_sat_add.sv
`default_nettype none
// ============================================================================
//  Module      : booth_sat_add
//  Description : Combinational saturating add of a sign-extended product onto
//                an ACC_W-bit signed accumulator; flags when clamping occurs.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_sat_add
  import booth_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              ovf_o
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // One guard bit is enough: |acc| + |prod| never exceeds ACC_W+1 signed bits.
  logic [ACC_W:0] w_sum;
  assign w_sum = {acc_i[ACC_W-1], acc_i}
               + {{(ACC_W+1-PROD_W){prod_i[PROD_W-1]}}, prod_i};

  // Guard bit disagreeing with the result sign means out of range; clamp by guard sign.
  always_comb begin
    ovf_o = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    sum_o = w_sum[ACC_W-1:0];
    if (ovf_o) begin
      sum_o = w_sum[ACC_W] ? SAT_MIN : SAT_MAX;
    end
  end

endmodule
`default_nettype wire

// File: rtl/booth_prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : booth_prod_accumulator
//  Description : Accepts a programmed number of signed products over a
//                valid/ready port, sums them with saturation and presents the
//                result on a valid/ready output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_prod_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic              ovf,
  output logic              busy
);

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   rem_q;
  logic               ovf_q;
  logic               prod_ready_q;
  logic               acc_valid_q;
  logic               busy_q;

  logic [ACC_W-1:0]   acc_d;
  logic               add_ovf;

  booth_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (prod),
    .sum_o  (acc_d),
    .ovf_o  (add_ovf)
  );

  // Run controller: handshake flags are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      acc_q        <= '0;
      rem_q        <= '0;
      ovf_q        <= 1'b0;
      prod_ready_q <= 1'b0;
      acc_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q  <= '0;
            ovf_q  <= 1'b0;
            rem_q  <= len;
            busy_q <= 1'b1;
            if (len == '0) begin
              state_q     <= ST_DONE;
              acc_valid_q <= 1'b1;
            end else begin
              state_q      <= ST_ACCUM;
              prod_ready_q <= 1'b1;
            end
          end
        end
        ST_ACCUM: begin
          if (prod_valid) begin
            acc_q <= acc_d;
            ovf_q <= ovf_q | add_ovf;
            rem_q <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1)) begin
              state_q      <= ST_DONE;
              prod_ready_q <= 1'b0;
              acc_valid_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // start is deliberately not looked at here; it is not queued.
          if (acc_ready) begin
            state_q     <= ST_IDLE;
            acc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          prod_ready_q <= 1'b0;
          acc_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = prod_ready_q;
  assign acc_valid  = acc_valid_q;
  assign acc_out    = acc_q;
  assign ovf        = ovf_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_prod_accumulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_prod_accumulator
//  Description : Self-checking bench for booth_prod_accumulator with a
//                saturating-sum reference model and directed plus random runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_prod_accumulator;

  localparam int PROD_W = 16;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 4;
  localparam int AMAX   = (1 <<< (ACC_W-1)) - 1;
  localparam int AMIN   = -(1 <<< (ACC_W-1));

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  len = '0;
  logic [PROD_W-1:0] prod = '0;
  logic              prod_valid = 1'b0;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              acc_valid;
  logic              acc_ready = 1'b0;
  logic              ovf;
  logic              busy;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int prods[$];

  booth_prod_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .prod       (prod),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .acc_out    (acc_out),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Count every product handshake the DUT takes.
  always @(posedge clk) begin
    if (rst_n && prod_valid && prod_ready) accepts <= accepts + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: running sum, clamped after every product, with sticky overflow flag.
  task automatic model(output int sum, output int sovf);
    longint s = 0;
    sovf = 0;
    foreach (prods[i]) begin
      s = s + prods[i];
      if (s > AMAX) begin s = AMAX; sovf = 1; end
      if (s < AMIN) begin s = AMIN; sovf = 1; end
    end
    sum = int'(s);
  endtask

  // One complete run over prods[]; gap<0 picks random 0..2 idle cycles per product.
  task automatic run_case(input string tag, input int gap, input int hold);
    int n = prods.size();
    int exp_sum, exp_ovf, base, g;
    model(exp_sum, exp_ovf);
    @(negedge clk);
    start = 1'b1; len = CNT_W'(n);
    base = accepts;
    @(negedge clk);
    start = 1'b0;
    if (n > 0) chk({tag, "_ready_on"}, {31'd0, prod_ready}, 1);
    else       chk({tag, "_len0_valid"}, {31'd0, acc_valid}, 1);
    foreach (prods[i]) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k < g; k++) begin
        prod_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_gap_novalid"}, {31'd0, acc_valid}, 0);
      end
      prod_valid = 1'b1;
      prod = PROD_W'(prods[i]);
      @(negedge clk);
    end
    // Leave prod_valid asserted to expose any accept past the programmed length.
    chk({tag, "_valid"}, {31'd0, acc_valid}, 1);
    chk({tag, "_acc"}, $signed(acc_out), exp_sum);
    chk({tag, "_ovf"}, {31'd0, ovf}, exp_ovf);
    chk({tag, "_ready_off"}, {31'd0, prod_ready}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    for (int h = 0; h < hold; h++) begin
      start = ~start;
      len = CNT_W'(3);
      @(negedge clk);
      chk({tag, "_hold_valid"}, {31'd0, acc_valid}, 1);
      chk({tag, "_hold_acc"}, $signed(acc_out), exp_sum);
      chk({tag, "_hold_ovf"}, {31'd0, ovf}, exp_ovf);
    end
    // start together with acc_ready must not begin a new run.
    start = 1'b1;
    acc_ready = 1'b1;
    prod_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    acc_ready = 1'b0;
    chk({tag, "_drop_valid"}, {31'd0, acc_valid}, 0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
    @(negedge clk);
    chk({tag, "_not_queued"}, {31'd0, busy}, 0);
    chk({tag, "_accepts"}, accepts - base, n);
  endtask

  initial begin
    int v;
    repeat (2) @(negedge clk);
    chk("rst_acc", $signed(acc_out), 0);
    chk("rst_valid", {31'd0, acc_valid}, 0);
    chk("rst_ready", {31'd0, prod_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    prods = '{100, -40, 7};
    run_case("t1", 0, 0);

    prods = '{5, 6};
    run_case("t2", 2, 1);

    prods.delete();
    repeat (15) prods.push_back(32767);
    run_case("t3a", 0, 0);
    prods = '{1, 1};
    run_case("t3b", 0, 0);

    prods.delete();
    repeat (15) prods.push_back(-32768);
    run_case("t4", 0, 0);

    prods.delete();
    run_case("t5", 0, 5);

    // Asynchronous reset mid-run: outputs clear without a clock edge.
    @(negedge clk);
    start = 1'b1; len = CNT_W'(3);
    @(negedge clk);
    start = 1'b0; prod_valid = 1'b1; prod = PROD_W'(1234);
    @(negedge clk);
    prod_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_acc", $signed(acc_out), 0);
    chk("t6_rst_ready", {31'd0, prod_ready}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_valid", {31'd0, acc_valid}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    prods = '{9};
    run_case("t6", 0, 0);

    for (int r = 0; r < 8; r++) begin
      prods.delete();
      v = int'($urandom_range(1, 15));
      for (int i = 0; i < v; i++) begin
        if ($urandom_range(0, 3) == 0)
          prods.push_back(($urandom_range(0, 1) == 1) ? 32767 : -32768);
        else
          prods.push_back(int'($signed(16'($urandom))));
      end
      run_case("rnd", -1, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
